// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier: two multiplier bits per cycle,
// signed or unsigned per transaction, start/busy/done handshake with abort.
//
// state | meaning
// IDLE  | waiting for start; product held
// CALC  | one radix-4 Booth step per cycle, counter runs ITER..1
// DONE  | product just written, done pulse; start accepted back-to-back
module booth_radix4_multiplier #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    signed_mode,
  input  logic [DATA_WIDTH-1:0]   multiplicand,
  input  logic [DATA_WIDTH-1:0]   multiplier,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int EXT_WIDTH  = DATA_WIDTH + 2 - (DATA_WIDTH % 2);
  localparam int ITER       = EXT_WIDTH / 2;
  localparam int CNT_WIDTH  = $clog2(ITER + 1);
  localparam int ACC_WIDTH  = EXT_WIDTH + 2;
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int PAD_WIDTH  = EXT_WIDTH - DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  m_ext;
  logic [ACC_WIDTH-1:0]  addend;
  logic [ACC_WIDTH-1:0]  sum;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [EXT_WIDTH-1:0]  m_reg;
  logic [EXT_WIDTH-1:0]  q_reg;
  logic [EXT_WIDTH-1:0]  q_next;
  logic                  q_m1;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [PROD_WIDTH-1:0] prod_next;
  logic                  accept;

  // Extension to EXT_WIDTH already encodes the mode, so M is always sign-extended here.
  assign m_ext = {{2{m_reg[EXT_WIDTH-1]}}, m_reg};

  always_comb begin
    addend = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
  end

  assign sum       = acc + addend;
  assign acc_next  = {{2{sum[ACC_WIDTH-1]}}, sum[ACC_WIDTH-1:2]};
  assign q_next    = {sum[1:0], q_reg[EXT_WIDTH-1:2]};
  // After ITER double-shifts the exact product sits in {acc[EXT-1:0], Q}.
  assign prod_next = PROD_WIDTH'({acc_next[EXT_WIDTH-1:0], q_next});
  assign accept    = start && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept) begin
            m_reg <= {{PAD_WIDTH{signed_mode & multiplicand[DATA_WIDTH-1]}}, multiplicand};
            q_reg <= {{PAD_WIDTH{signed_mode & multiplier[DATA_WIDTH-1]}}, multiplier};
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_WIDTH'(ITER);
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        CALC: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            q_reg <= q_next;
            q_m1  <= q_reg[1];
            cnt   <= cnt - CNT_WIDTH'(1);
            if (cnt == CNT_WIDTH'(1)) begin
              product <= prod_next;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Directed bench for booth_radix4_multiplier: an 8-bit instance driven from a
// vector table plus handshake corner sequences, and a 3-bit instance for odd widths.
module tb_booth_radix4_multiplier;

  logic        clk;
  logic        rst;

  logic        start8, abort8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  logic        start3, abort3, sm3;
  logic [2:0]  a3, b3;
  logic        busy3, done3;
  logic [5:0]  product3;

  int n_checks;
  int n_fail;

  booth_radix4_multiplier #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8), .product(product8)
  );

  booth_radix4_multiplier #(.DATA_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .signed_mode(sm3),
    .multiplicand(a3), .multiplier(b3), .busy(busy3), .done(done3), .product(product3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec8_t;

  typedef struct {
    logic       sm;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] exp;
  } vec3_t;

  vec8_t vecs8[11];
  vec3_t vecs3[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture edge happens inside; returns in cycle 1 with operands scrambled.
  task automatic start_op8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
  endtask

  // Called in cycle 1; returns in the done cycle (or at the budget limit).
  task automatic wait_done8(output int cyc, output int busy_n);
    cyc = 1;
    busy_n = 0;
    while (!done8 && cyc < 20) begin
      if (busy8) busy_n++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, busy_n;
    n_checks = 0;
    n_fail = 0;

    vecs8[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs8[1]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs8[2]  = '{1'b0, 8'hFD, 8'h05, 16'h04F1};
    vecs8[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs8[4]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs8[5]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs8[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs8[7]  = '{1'b1, 8'h07, 8'hFA, 16'hFFD6};
    vecs8[8]  = '{1'b0, 8'h00, 8'hAB, 16'h0000};
    vecs8[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs8[10] = '{1'b0, 8'h0C, 8'h0D, 16'h009C};

    vecs3[0] = '{1'b1, 3'b100, 3'b100, 6'b010000};
    vecs3[1] = '{1'b0, 3'b111, 3'b111, 6'b110001};
    vecs3[2] = '{1'b1, 3'b011, 3'b100, 6'b110100};
    vecs3[3] = '{1'b0, 3'b100, 3'b110, 6'b011000};

    rst = 1'b0;
    start8 = 1'b0; abort8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; abort3 = 1'b0; sm3 = 1'b0; a3 = '0; b3 = '0;
    #12;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_product", 32'(product8), 32'd0);
    check("reset_product3", 32'(product3), 32'd0);
    #10;
    rst = 1'b1;
    tick();

    // Table vectors: latency, busy span, product and single-cycle done.
    for (int i = 0; i < 11; i++) begin
      start_op8(vecs8[i].sm, vecs8[i].a, vecs8[i].b);
      wait_done8(cyc, busy_n);
      check($sformatf("vec%0d_done_cycle", i), 32'(cyc), 32'd6);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd5);
      check($sformatf("vec%0d_busy_in_done", i), 32'(busy8), 32'd0);
      check($sformatf("vec%0d_product", i), 32'(product8), 32'(vecs8[i].exp));
      tick();
      check($sformatf("vec%0d_done_drop", i), 32'(done8), 32'd0);
      check($sformatf("vec%0d_product_hold", i), 32'(product8), 32'(vecs8[i].exp));
    end

    // Back-to-back: start held in DONE; a start during CALC is ignored.
    start_op8(1'b1, 8'h03, 8'h04);
    wait_done8(cyc, busy_n);
    check("b2b_first_product", 32'(product8), 32'h000C);
    sm8 = 1'b1; a8 = 8'h07; b8 = 8'hFA; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h01; b8 = 8'h01;
    check("b2b_busy_c1", 32'(busy8), 32'd1);
    tick();
    tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 4;
    while (!done8 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b_second_done_cycle", 32'(cyc), 32'd6);
    check("b2b_second_product", 32'(product8), 32'hFFD6);
    tick();
    check("b2b_no_restart", 32'(busy8), 32'd0);

    // Abort mid-operation keeps the previous product.
    start_op8(1'b0, 8'hE9, 8'h14);
    wait_done8(cyc, busy_n);
    check("abort_setup_product", 32'(product8), 32'h1234);
    tick();
    start_op8(1'b0, 8'h02, 8'h03);
    tick();
    tick();
    check("abort_busy_c3", 32'(busy8), 32'd1);
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    check("abort_busy_after", 32'(busy8), 32'd0);
    busy_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (done8 || busy8) busy_n++;
      tick();
    end
    check("abort_no_done", 32'(busy_n), 32'd0);
    check("abort_product_kept", 32'(product8), 32'h1234);

    // Start together with abort in IDLE is ignored.
    sm8 = 1'b0; a8 = 8'h02; b8 = 8'h03; start8 = 1'b1; abort8 = 1'b1;
    tick();
    start8 = 1'b0; abort8 = 1'b0;
    check("idle_abort_start_busy", 32'(busy8), 32'd0);
    busy_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (done8 || busy8) busy_n++;
      tick();
    end
    check("idle_abort_no_done", 32'(busy_n), 32'd0);
    check("idle_abort_product", 32'(product8), 32'h1234);

    // Start with abort in DONE: done pulse still there, then IDLE.
    start_op8(1'b1, 8'hFE, 8'h03);
    wait_done8(cyc, busy_n);
    check("done_abort_pulse", 32'(done8), 32'd1);
    check("done_abort_product", 32'(product8), 32'hFFFA);
    start8 = 1'b1; abort8 = 1'b1;
    tick();
    start8 = 1'b0; abort8 = 1'b0;
    check("done_abort_busy", 32'(busy8), 32'd0);
    check("done_abort_done", 32'(done8), 32'd0);

    // Odd width: ITER=2, done in cycle 3.
    for (int i = 0; i < 4; i++) begin
      sm3 = vecs3[i].sm; a3 = vecs3[i].a; b3 = vecs3[i].b; start3 = 1'b1;
      tick();
      start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom);
      cyc = 1;
      while (!done3 && cyc < 20) begin
        tick();
        cyc++;
      end
      check($sformatf("w3_vec%0d_done_cycle", i), 32'(cyc), 32'd3);
      check($sformatf("w3_vec%0d_product", i), 32'(product3), 32'(vecs3[i].exp));
      tick();
    end

    // Asynchronous reset in cycle 2 of an operation.
    start_op8(1'b0, 8'h12, 8'h34);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy8), 32'd0);
    check("rst_mid_done", 32'(done8), 32'd0);
    check("rst_mid_product", 32'(product8), 32'd0);
    tick();
    #2;
    rst = 1'b1;
    busy_n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done8 || busy8) busy_n++;
    end
    check("rst_mid_no_done", 32'(busy_n), 32'd0);
    check("rst_mid_product_after", 32'(product8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_radix4_multiplier.md
Name: booth_radix4_multiplier

Overview:
Parametrised sequential radix-4 (modified Booth) multiplier, the next generation of the radix-2 Booth unit in the arithmetic datapath. Retires two multiplier bits per cycle. Selects signed or unsigned operation per transaction. Uses a start/busy/done handshake with abort, and holds its result in a dedicated product register. Sits beside the ALU and is driven by the same control sequencers.

Parameters:
DATA_WIDTH, 8, operand width in bits; legal values are 2 and above, odd widths included.
EXT_WIDTH, DATA_WIDTH+2-(DATA_WIDTH%2), derived and not overridable; internal extended operand width (always even).
ITER, EXT_WIDTH/2, derived; number of radix-4 iterations.
CNT_WIDTH, $clog2(ITER+1), derived; iteration counter width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE or DONE.
abort  input  1  cancel an operation in flight.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
multiplicand  input  DATA_WIDTH  operand A; captured with start.
multiplier  input  DATA_WIDTH  operand B; captured with start.
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse when product is updated.
product  output  2*DATA_WIDTH  registered result; held between operations.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, product=0; internal accumulator, multiplier shift register, Booth guard bit and counter all cleared.
- FSM states are IDLE, CALC and DONE; all outputs are registered or decoded from state only.
- IDLE, start=1, abort=0: on the clock edge, capture the operands extended to EXT_WIDTH.
  - signed_mode=1: sign-extend both operands.
  - signed_mode=0: zero-extend both operands.
  - Clear the accumulator and the guard bit q(-1), load counter=ITER, go to CALC.
- CALC, each cycle:
  - Examine the triplet {Q[1],Q[0],q(-1)} and add 0, +M, +2M, -M or -2M to the accumulator, using standard radix-4 Booth recoding.
  - Arithmetic-shift the combined {accumulator, Q, q(-1)} right by 2.
  - Decrement the counter.
  - The accumulator is EXT_WIDTH+2 bits wide so ±2M never overflows.
- CALC with counter reaching 0 after the update: go to DONE.
- DONE (exactly one cycle): done=1, busy=0. Product is loaded on the CALC-to-DONE edge with the low 2*DATA_WIDTH bits of the exact product, so it is valid in the cycle done=1.
- From DONE: go to IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back operation).
- Latency: with start sampled at edge 0, busy is high for cycles 1..ITER and done=1 in cycle ITER+1 (cycle 6 for DATA_WIDTH=8). Throughput is one result per ITER+1 cycles.
- start while busy=1: ignored; captured operands are unaffected.
- abort=1 in CALC: go to IDLE at the next edge; no done pulse; product retains its previous value.
- abort=1 together with start in IDLE or DONE: abort wins, start is ignored, and the block stays in or goes to IDLE. In DONE the done pulse still occurs because the product was already written.
- Operand inputs may change freely after the capture edge.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- Result is exact for every operand pair in both modes, including most-negative by most-negative and DATA_WIDTH odd.

Test Plan:
- DATA_WIDTH=8, signed_mode=1, A=0x80, B=0x80, start pulse at edge 0 -> busy high in cycles 1-5; done=1 and product=0x4000 in cycle 6; done=0 in cycle 7.
- signed_mode=1, A=0xFD (-3), B=0x05 -> product=0xFFF1. Repeat with signed_mode=0 (253*5) -> product=0x04F1.
- signed_mode=0, A=0xFF, B=0xFF -> product=0xFE01.
- Back-to-back: start held high in the DONE cycle with A=7, B=-6 (signed) -> second done 6 cycles later, product=0xFFD6. A start in cycle 3 of that operation is ignored.
- Abort at cycle 3 of A=2, B=3, with product previously 0x1234 -> no done; product stays 0x1234; busy=0 the next cycle. A start asserted with abort in IDLE is ignored.
- DATA_WIDTH=3 build: signed -4*-4 -> product=6'b010000 after ITER=2 (done in cycle 3). Separately, rst pulsed low in cycle 2 of an 8-bit operation -> busy, done and product immediately 0; no done afterwards.
